sysid_checker: RTL and testbench
================================

SYSID_CHECKER -- requirements
Module: sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'h0000_0000, is the system ID value the SoC must report at address 0.
REQ-002 Parameter EXPECTED_TS, default 32'h5480_8475, is the generation timestamp the SoC must report at address 1.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, is the maximum number of cycles a read may stall on waitrequest.
REQ-004 Parameter MAX_RETRIES, default 3, is the number of full re-check passes allowed after the first mismatch.
REQ-005 Port clock  in  1  sole clock; all logic is on its rising edge.
REQ-006 Port reset  in  1  synchronous, active-high reset.
REQ-007 Port start  in  1  single-cycle request to run a check pass.
REQ-008 Port avm_address  out  1  Avalon-MM master word address (0 = ID, 1 = timestamp).
REQ-009 Port avm_read  out  1  Avalon-MM read strobe.
REQ-010 Port avm_readdata  in  32  read data, valid in any cycle with avm_read=1 and avm_waitrequest=0.
REQ-011 Port avm_waitrequest  in  1  slave stall.
REQ-012 Port busy  out  1  high while a check is in progress.
REQ-013 Port done  out  1  one-cycle pulse when a check finishes.
REQ-014 Port pass  out  1  sticky result: both values matched on the final pass.
REQ-015 Port timeout  out  1  sticky: a read exceeded TIMEOUT_CYCLES.
REQ-016 Port id_value, ts_value  out  32 each  last captured ID and timestamp words.

Function
REQ-017 The FSM states are IDLE, RD_ID, RD_TS, CHECK and FINISH.
REQ-018 IDLE -> RD_ID on start=1; this clears pass and timeout, and loads the retry counter with MAX_RETRIES.
REQ-019 RD_ID drives avm_read=1 and avm_address=0; when waitrequest=0, it captures readdata into id_value and moves to RD_TS on the next cycle.
REQ-020 RD_TS drives avm_read=1 and avm_address=1; when waitrequest=0, it captures readdata into ts_value and moves to CHECK.
REQ-021 Address and read are held stable while waitrequest=1 (Avalon rule); avm_read=0 in IDLE, CHECK and FINISH.
REQ-022 CHECK compares id_value against EXPECTED_ID and ts_value against EXPECTED_TS.
REQ-023 On a match in CHECK: pass=1, go to FINISH.
REQ-024 On a mismatch in CHECK with retry counter > 0: decrement the counter and return to RD_ID.
REQ-025 On a mismatch in CHECK with retry counter = 0: pass=0, go to FINISH.
REQ-026 The wait counter resets on entry to each read state and increments each cycle that waitrequest=1.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES, the block sets timeout=1, sets pass=0, drops avm_read on the next cycle, and goes to FINISH with no retry.
REQ-028 FINISH asserts done for exactly one cycle, then returns to IDLE.
REQ-029 busy=1 in every state except IDLE.
REQ-030 start while busy=1 is ignored; start in the same cycle that FINISH is active is also ignored.
REQ-031 Latency with no waitrequest and a match: start at cycle 0; reads in cycles 1 and 2; CHECK in cycle 3; done in cycle 4.
REQ-032 The wait counter is sized $clog2(TIMEOUT_CYCLES+1) and saturates; it never wraps.

Reset
REQ-033 When reset=1 at a clock edge: state=IDLE, avm_read=0, avm_address=0, busy=0, done=0, pass=0, timeout=0, id_value=0, ts_value=0, all counters=0.
REQ-034 Reset asserted mid-read aborts the transaction; avm_read is 0 in the cycle after the reset edge, and no done pulse is produced.

Structure
REQ-035 The state enum, the address constants ADDR_ID=0 and ADDR_TS=1, and the default EXPECTED_* values belong in the package sysid_checker_pkg.
REQ-036 The wait counter with saturation and expiry flag is a single sub-module, sysid_checker_timer, instantiated once.

Verification
REQ-037 Matching slave with waitrequest=0 and start pulse: done at cycle 4, pass=1, id_value=0, ts_value=32'h5480_8475, and exactly 2 reads.
REQ-038 Slave returns ts 32'h5480_8476 always: 8 reads total (4 passes), then done with pass=0 and timeout=0.
REQ-039 Slave returns a bad ts on pass 1 and a correct ts on pass 2: done with pass=1 after 4 reads.
REQ-040 waitrequest held at 1 during the ID read: avm_read drops after 16 stall cycles, then timeout=1, pass=0 and a single done pulse.
REQ-041 waitrequest=1 for 3 cycles on each read: address stays stable throughout, pass=1, and done arrives 6 cycles later than in REQ-037.
REQ-042 reset asserted during RD_TS: next cycle state=IDLE, avm_read=0, no done; a subsequent start completes normally.

Source files
------------

// File: rtl/sysid_checker_pkg.sv
// sysid_checker_pkg: shared types and constants for the system-ID checker.
//   state_e             - checker FSM states
//   ADDR_ID / ADDR_TS   - Avalon word addresses of the ID and timestamp registers
//   DEFAULT_EXPECTED_*  - default reference values for the checker parameters
package sysid_checker_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRdId,
      StRdTs,
      StCheck,
      StFinish
   } state_e;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

   localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5480_8475;

endpackage

// File: rtl/sysid_checker_if.sv
// sysid_checker_if: Avalon-MM read-only bus between the checker and the sysid slave.
//   address     - word address (0 = ID, 1 = timestamp)
//   read        - read strobe
//   readdata    - read data, valid when read=1 and waitrequest=0
//   waitrequest - slave stall
interface sysid_checker_if;

   logic        address;
   logic        read;
   logic [31:0] readdata;
   logic        waitrequest;

   modport master (
      output address,
      output read,
      input  readdata,
      input  waitrequest
   );

   modport slave (
      input  address,
      input  read,
      output readdata,
      output waitrequest
   );

endinterface

// File: rtl/sysid_checker_timer.sv
// sysid_checker_timer: saturating stall counter for one Avalon read.
//   clock, reset - clock and synchronous active-high reset
//   clear        - restart counting from zero (read state entry)
//   inc          - this cycle is a stall cycle
//   expired      - this stall cycle is the TIMEOUT_CYCLES-th one of the read
module sysid_checker_timer #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);

   logic [CntW-1:0] count_q;

   // Flag on the stall that brings the count to the limit, so the read strobe
   // is gone in the very next cycle.
   assign expired = inc && (count_q >= Limit - 1'b1);

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (inc && (count_q != Limit)) begin
         count_q <= count_q + 1'b1;
      end
   end

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker: reads the SoC system-ID and timestamp over Avalon-MM and checks them.
//   clock, reset       - clock and synchronous active-high reset
//   start              - single-cycle request to run a check (ignored while busy)
//   avm                - Avalon-MM master port (sysid_checker_if.master)
//   busy               - check in progress
//   done               - one-cycle pulse at the end of a check
//   pass, timeout      - sticky results of the last check
//   id_value, ts_value - last captured ID and timestamp words
module sysid_checker
   import sysid_checker_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned MAX_RETRIES    = 3
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    start,
   sysid_checker_if.master         avm,
   output logic                    busy,
   output logic                    done,
   output logic                    pass,
   output logic                    timeout,
   output logic [31:0]             id_value,
   output logic [31:0]             ts_value
);

   localparam int unsigned RetryW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
   localparam logic [RetryW-1:0] RetryInit = RetryW'(MAX_RETRIES);

   state_e            state_q, state_d;
   logic              pass_q, pass_d;
   logic              timeout_q, timeout_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [31:0]       id_q, id_d;
   logic [31:0]       ts_q, ts_d;
   logic              in_read;
   logic              expired;

   assign in_read = (state_q == StRdId) || (state_q == StRdTs);

   // Any state change clears the counter, which covers entry to each read state.
   sysid_checker_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock   (clock),
      .reset   (reset),
      .clear   (state_d != state_q),
      .inc     (in_read && avm.waitrequest),
      .expired (expired)
   );

   always_comb begin
      state_d   = state_q;
      pass_d    = pass_q;
      timeout_d = timeout_q;
      retry_d   = retry_q;
      id_d      = id_q;
      ts_d      = ts_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d   = StRdId;
               pass_d    = 1'b0;
               timeout_d = 1'b0;
               retry_d   = RetryInit;
            end
         end
         StRdId: begin
            if (expired) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = StFinish;
            end else if (!avm.waitrequest) begin
               id_d    = avm.readdata;
               state_d = StRdTs;
            end
         end
         StRdTs: begin
            if (expired) begin
               timeout_d = 1'b1;
               pass_d    = 1'b0;
               state_d   = StFinish;
            end else if (!avm.waitrequest) begin
               ts_d    = avm.readdata;
               state_d = StCheck;
            end
         end
         StCheck: begin
            if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS)) begin
               pass_d  = 1'b1;
               state_d = StFinish;
            end else if (retry_q != '0) begin
               retry_d = retry_q - 1'b1;
               state_d = StRdId;
            end else begin
               pass_d  = 1'b0;
               state_d = StFinish;
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         pass_q    <= 1'b0;
         timeout_q <= 1'b0;
         retry_q   <= '0;
         id_q      <= '0;
         ts_q      <= '0;
      end else begin
         state_q   <= state_d;
         pass_q    <= pass_d;
         timeout_q <= timeout_d;
         retry_q   <= retry_d;
         id_q      <= id_d;
         ts_q      <= ts_d;
      end
   end

   // Bus outputs decode the registered state only, so they hold steady under stalls.
   assign avm.read    = in_read;
   assign avm.address = (state_q == StRdTs) ? ADDR_TS : ADDR_ID;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StFinish);
   assign pass        = pass_q;
   assign timeout     = timeout_q;
   assign id_value    = id_q;
   assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_checker.sv
module tb_sysid_checker;

   localparam logic [31:0] GoodTs = 32'h5480_8475;
   localparam logic [31:0] BadTs  = 32'h5480_8476;

   typedef struct {
      int          id_bad;     // passes on which the slave returns a wrong ID
      int          ts_bad;     // passes on which the slave returns a wrong timestamp
      int          stall;      // waitrequest cycles per read
      bit          hang;       // waitrequest stuck high
      bit          exp_pass;
      bit          exp_to;
      int          exp_reads;
      int          exp_stalls;
      int          exp_lat;
      logic [31:0] exp_id;
      logic [31:0] exp_ts;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        busy, done, pass, timeout;
   logic [31:0] id_value, ts_value;

   sysid_checker_if avm ();

   sysid_checker dut (
      .clock    (clock),
      .reset    (reset),
      .start    (start),
      .avm      (avm),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .timeout  (timeout),
      .id_value (id_value),
      .ts_value (ts_value)
   );

   always #5 clock = ~clock;

   // Slave configuration and monitor state
   int   cfg_id_bad = 0;
   int   cfg_ts_bad = 0;
   int   cfg_stall  = 0;
   bit   cfg_hang   = 1'b0;
   logic mon_clr    = 1'b0;

   int   cyc = 0;
   int   rd_cnt, stall_total, id_rd, stall_cnt, done_cnt, done_cyc, addr_err;
   logic held_q, prev_addr;

   int   n_cmp = 0;
   int   n_fail = 0;

   assign avm.waitrequest = cfg_hang || (avm.read && (stall_cnt < cfg_stall));
   assign avm.readdata    = (avm.address == 1'b0) ?
                            ((id_rd < cfg_id_bad) ? 32'h0000_0001 : 32'h0000_0000) :
                            ((id_rd <= cfg_ts_bad) ? BadTs : GoodTs);

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         rd_cnt      <= 0;
         stall_total <= 0;
         id_rd       <= 0;
         stall_cnt   <= 0;
         done_cnt    <= 0;
         done_cyc    <= 0;
         addr_err    <= 0;
         held_q      <= 1'b0;
         prev_addr   <= 1'b0;
      end else begin
         if (avm.read && !avm.waitrequest) begin
            rd_cnt    <= rd_cnt + 1;
            stall_cnt <= 0;
            if (avm.address == 1'b0) id_rd <= id_rd + 1;
         end else if (avm.read && avm.waitrequest) begin
            stall_cnt   <= stall_cnt + 1;
            stall_total <= stall_total + 1;
         end
         if (held_q && avm.read && (avm.address != prev_addr)) addr_err <= addr_err + 1;
         held_q    <= avm.read && avm.waitrequest;
         prev_addr <= avm.address;
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(posedge clock);
      #1 mon_clr = 1'b0;
   endtask

   // Pulses start for one cycle; returns the cycle number of the start cycle.
   task automatic pulse_start(output int t0);
      start = 1'b1;
      t0    = cyc;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic wait_done_settle();
      for (int k = 0; k < 80 && done_cnt == 0; k++) @(posedge clock);
      #1;
      repeat (3) @(posedge clock);
      #1;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int t0;
      string p;
      p          = $sformatf("vec%0d", idx);
      cfg_id_bad = v.id_bad;
      cfg_ts_bad = v.ts_bad;
      cfg_stall  = v.stall;
      cfg_hang   = v.hang;
      clear_mon();
      pulse_start(t0);
      wait_done_settle();
      chk({p, " done_count"}, done_cnt, 1);
      chk({p, " latency"}, done_cyc - t0, v.exp_lat);
      chk({p, " busy_after"}, busy, 1'b0);
      chk({p, " pass"}, pass, v.exp_pass);
      chk({p, " timeout"}, timeout, v.exp_to);
      chk({p, " reads"}, rd_cnt, v.exp_reads);
      chk({p, " stalls"}, stall_total, v.exp_stalls);
      chk({p, " id_value"}, id_value, v.exp_id);
      chk({p, " ts_value"}, ts_value, v.exp_ts);
      chk({p, " addr_stable"}, addr_err, 0);
      chk({p, " read_idle"}, avm.read, 1'b0);
      cfg_hang = 1'b0;
   endtask

   vec_t vecs[6];

   initial begin
      int t0;
      //          id_bad ts_bad stall hang pass to  reads stalls lat  id            ts
      vecs[0] = '{0,     0,     0,    0,   1,   0,  2,    0,     4,   32'h0,        GoodTs};
      vecs[1] = '{0,     0,     0,    1,   0,   1,  0,    16,    17,  32'h0,        GoodTs};
      vecs[2] = '{0,     99,    0,    0,   0,   0,  8,    0,     13,  32'h0,        BadTs};
      vecs[3] = '{0,     1,     0,    0,   1,   0,  4,    0,     7,   32'h0,        GoodTs};
      vecs[4] = '{0,     0,     3,    0,   1,   0,  2,    6,     10,  32'h0,        GoodTs};
      vecs[5] = '{99,    0,     0,    0,   0,   0,  8,    0,     13,  32'h1,        GoodTs};

      mon_clr = 1'b1;
      reset   = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      chk("rst busy", busy, 1'b0);
      chk("rst done", done, 1'b0);
      chk("rst pass", pass, 1'b0);
      chk("rst timeout", timeout, 1'b0);
      chk("rst read", avm.read, 1'b0);
      chk("rst address", avm.address, 1'b0);
      chk("rst id_value", id_value, 32'h0);
      chk("rst ts_value", ts_value, 32'h0);
      reset   = 1'b0;
      mon_clr = 1'b0;
      @(posedge clock);
      #1;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Extra start pulses while busy must not lengthen or repeat the check.
      cfg_id_bad = 0; cfg_ts_bad = 0; cfg_stall = 0;
      clear_mon();
      pulse_start(t0);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      wait_done_settle();
      chk("busy_start done_count", done_cnt, 1);
      chk("busy_start latency", done_cyc - t0, 4);
      chk("busy_start reads", rd_cnt, 2);

      // Start coinciding with the FINISH cycle is dropped.
      clear_mon();
      pulse_start(t0);
      repeat (3) @(posedge clock);
      #1;
      chk("fin_start done_high", done, 1'b1);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
      chk("fin_start busy", busy, 1'b0);
      repeat (3) @(posedge clock);
      #1;
      chk("fin_start busy_later", busy, 1'b0);
      chk("fin_start done_count", done_cnt, 1);

      // Reset during the timestamp read aborts cleanly.
      clear_mon();
      pulse_start(t0);
      @(posedge clock);
      #1;
      chk("rst_mid in_rd_ts", {avm.read, avm.address}, 2'b11);
      reset = 1'b1;
      @(posedge clock);
      #1;
      chk("rst_mid read", avm.read, 1'b0);
      chk("rst_mid busy", busy, 1'b0);
      reset = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      chk("rst_mid done_count", done_cnt, 0);
      chk("rst_mid id_cleared", id_value, 32'h0);
      run_vec(6, vecs[0]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
